piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out unloader for a WIDTH-bit word. It is the reading end of a parallel load register: it accepts a word on a load strobe, then shifts it out one bit per accepted handshake, MSB first by default. It pulses `done` when the last bit has been taken. It sits between word-wide datapath registers and bit-serial consumers such as a UART TX core or an SPI MOSI driver.

## Interface
- `WIDTH`, default 8: word size in bits; legal for any value ≥ 1.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset; clears all state immediately.
- `d`  in  WIDTH: parallel word to serialize.
- `ld`  in  1: load request; accepted only when `ld & ready`.
- `ready`  out  1: high in IDLE, meaning the block can accept a word.
- `sout`  out  1: current serial bit.
- `sout_valid`  out  1: `sout` holds a valid bit.
- `sout_ready`  in  1: the consumer takes the bit when `sout_valid & sout_ready`.
- `done`  out  1: one-cycle pulse after the final bit is accepted.

## Operation
- Reset values: state IDLE, shift register 0, counter 0, `ready`=1, `sout`=0, `sout_valid`=0, `done`=0.
- FSM states:
  - IDLE: `ready`=1, `sout_valid`=0, `sout`=0.
  - SHIFT: `ready`=0, `sout_valid`=1.
- Transition IDLE→SHIFT on `ld`: capture `d` into the shift register and clear the bit counter.
- In SHIFT, `sout` is `shreg[WIDTH-1]` when MSB_FIRST=1, otherwise `shreg[0]`.
- On each `sout_valid & sout_ready` in SHIFT:
  - shift toward the output end with zero fill;
  - increment the counter.
- When the counter equals WIDTH-1 at a handshake, transition SHIFT→IDLE and set `done`=1 for the next cycle.
- `ld` is ignored in SHIFT. No queuing: the word is dropped and the upstream must hold `ld` until `ready`.
- Stall: while `sout_ready`=0, `sout`, `sout_valid` and all state hold.
- Counter width is max(1, $clog2(WIDTH)).
- WIDTH=1: a single handshake returns the block to IDLE with `done`.
- Reset asserted mid-word: the word is discarded, no `done` is produced, and the block returns to IDLE asynchronously.
- `done` and `ld` in the same cycle is legal: the new word is accepted and `done` still pulses for the old word.

## Timing
- All outputs derive from registered state only; there is no combinational path from any input to any output.
- `ld` accepted at edge N: `sout_valid`=1 with the first bit from just after edge N.
- Bit i is handed off at the i-th handshake edge. With `sout_ready` held high, the last bit is accepted at edge N+WIDTH.
- After the last-bit edge: `ready`=1 and `done`=1 for exactly one cycle.
- Minimum word period is WIDTH+1 cycles: one IDLE cycle between words.
- Reset deassertion must be synchronized upstream; the block may leave reset in any cycle.

## Structure
- Shared package `piso_pkg`: typedef enum logic `piso_state_e` {IDLE, SHIFT}.
- One sub-module, `bit_counter`: parameterized up-counter with synchronous clear, enable, and a registered terminal-count compare output (`tc` when count == WIDTH-1).
- Shift register, FSM and `done` flop live in `piso_serializer`.

## Test plan
- Reset check: assert `rst` mid-cycle with no clock edge. Outputs go to `ready`=1, `sout_valid`=0, `sout`=0, `done`=0 immediately.
- WIDTH=8, MSB_FIRST=1, `d`=8'hA5, `sout_ready`=1: `sout` sequence is 1,0,1,0,0,1,0,1. `done` pulses exactly 8 cycles after the load edge, and `ready` returns at the same time.
- MSB_FIRST=0, `d`=8'h01, with `sout_ready` toggling 1,0,1,0…: `sout` sequence is 1,0,0,0,0,0,0,0. Each bit holds through its stall cycles, and `done` pulses after the 8th handshake.
- Pulse `ld` with `d`=8'hFF during SHIFT of 8'h00: it is ignored, and all 8 bits are 0. Then assert `ld` in the `done` cycle: 8'hFF is accepted and the next 8 bits are 1.
- Assert `rst` after 3 bits of 8'hC3: no `done` pulse, and the state is IDLE. A following load of 8'h3C serializes cleanly as 0,0,1,1,1,1,0,0.
- WIDTH=1, `d`=1'b1: one cycle with `sout_valid`=1 and `sout`=1, then `done` and `ready`; back-to-back loads give a period of 2 cycles.

Source files
------------

// File: rtl/piso_pkg.sv
`default_nettype none
// =====================================================================
// Package : piso_pkg
// Shared state encoding and sizing helper for the PISO serializer.
// Rev     : 1.0
// =====================================================================
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // A one-bit word still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_bit_counter.sv
`default_nettype none
// =====================================================================
// Module : bit_counter
// Up-counter with synchronous clear/enable and a registered terminal count.
// Rev    : 1.0
// =====================================================================
module bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned     c_cw   = cnt_width(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    logic [c_cw-1:0] count_q, count_d;
    logic            tc_q, tc_d;

    // tc is computed from the next count so it lines up with count_q.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = count_q + 1'b1;
        end
        tc_d = (count_d == c_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= (c_last == '0);
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign o_tc = tc_q;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// =====================================================================
// Module : piso_serializer
// Loads a WIDTH-bit word and shifts it out one bit per valid/ready handshake.
// Rev    : 1.0
// =====================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done
);

    localparam int unsigned c_out_idx = MSB_FIRST ? WIDTH - 1 : 0;

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic             ready_q, ready_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (cnt_clr),
        .i_en  (cnt_en),
        .o_tc  (cnt_tc)
    );

    assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // sout is registered as the bit that will sit at the output end next cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    state_d = SHIFT;
                    shreg_d = d;
                    cnt_clr = 1'b1;
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                    sout_d  = d[c_out_idx];
                end
            end
            SHIFT: begin
                if (sout_ready) begin
                    cnt_en  = 1'b1;
                    shreg_d = shifted;
                    if (cnt_tc) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        valid_d = 1'b0;
                        sout_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sout_d  = shifted[c_out_idx];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            ready_q <= 1'b1;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign ready      = ready_q;
    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// =====================================================================
// Module : tb_piso_serializer
// Scoreboard bench: MSB-first and LSB-first 8-bit instances plus a 1-bit one.
// Rev    : 1.0
// =====================================================================
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0] d_m = '0, d_l = '0;
    logic [0:0] d_1 = '0;
    logic ld_m = 1'b0, ld_l = 1'b0, ld_1 = 1'b0;
    logic r_m = 1'b1, r_l = 1'b1, r_1 = 1'b1;
    logic rdy_m, rdy_l, rdy_1;
    logic so_m, so_l, so_1;
    logic sv_m, sv_l, sv_1;
    logic done_m, done_l, done_1;

    bit q_m[$];
    bit q_l[$];
    bit q_1[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .d(d_m), .ld(ld_m), .ready(rdy_m), .sout(so_m),
        .sout_valid(sv_m), .sout_ready(r_m), .done(done_m));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .d(d_l), .ld(ld_l), .ready(rdy_l), .sout(so_l),
        .sout_valid(sv_l), .sout_ready(r_l), .done(done_l));

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_1 (
        .clk(clk), .rst(rst), .d(d_1), .ld(ld_1), .ready(rdy_1), .sout(so_1),
        .sout_valid(sv_1), .sout_ready(r_1), .done(done_1));

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic extra_bit(input string nm, input logic act);
        n_vec++;
        n_err++;
        $display("FAIL %s: sout=%b presented with no expected bit at %0t", nm, act, $time);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ready_m"}, rdy_m, 1'b1);
        chk({nm, "_valid_m"}, sv_m, 1'b0);
        chk({nm, "_sout_m"}, so_m, 1'b0);
        chk({nm, "_done_m"}, done_m, 1'b0);
        chk({nm, "_ready_l"}, rdy_l, 1'b1);
        chk({nm, "_valid_1"}, sv_1, 1'b0);
    endtask

    task automatic issue_m(input logic [7:0] w);
        @(posedge clk); #1;
        d_m  = w;
        ld_m = 1'b1;
        for (int i = 7; i >= 0; i--) q_m.push_back(w[i]);
        @(posedge clk); #1;
        ld_m = 1'b0;
    endtask

    task automatic done_window_m(input string nm, input int last_e);
        for (int e = 0; e <= last_e; e++) begin
            @(negedge clk);
            chk({nm, "_done"}, done_m, e == 8);
            chk({nm, "_ready"}, rdy_m, e >= 8);
        end
    endtask

    initial begin
        bit tmp;
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (sv_m) begin
                        if (q_m.size() == 0) extra_bit("m_extra", so_m);
                        else begin
                            chk("m_sout", so_m, q_m[0]);
                            if (r_m) tmp = q_m.pop_front();
                        end
                    end
                    if (sv_l) begin
                        if (q_l.size() == 0) extra_bit("l_extra", so_l);
                        else begin
                            chk(r_l ? "l_sout" : "l_sout_stall", so_l, q_l[0]);
                            if (r_l) tmp = q_l.pop_front();
                        end
                    end
                    if (sv_1) begin
                        if (q_1.size() == 0) extra_bit("w1_extra", so_1);
                        else begin
                            chk("w1_sout", so_1, q_1[0]);
                            if (r_1) tmp = q_1.pop_front();
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Asynchronous reset with no clock edge yet
        #2 rst = 1'b1;
        #1 chk_idle_outputs("rst0");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // A5, MSB first, consumer always ready
        issue_m(8'hA5);
        done_window_m("a5", 9);

        // 00 with an ignored FF load mid-word, then FF loaded in the done cycle
        @(posedge clk); #1;
        d_m  = 8'h00;
        ld_m = 1'b1;
        for (int i = 0; i < 8; i++) q_m.push_back(1'b0);
        @(posedge clk); #1;
        ld_m = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            @(negedge clk);
            chk("ign_done", done_m, e == 8);
            @(posedge clk); #1;
            ld_m = (e == 2) || (e == 7);
            d_m  = 8'hFF;
            if (e == 7) for (int i = 0; i < 8; i++) q_m.push_back(1'b1);
        end
        done_window_m("ff", 9);

        // C3 interrupted by reset after three bits
        issue_m(8'hC3);
        for (int e = 0; e <= 2; e++) begin
            @(negedge clk);
            chk("c3_done", done_m, 1'b0);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        q_m.delete();
        #1 chk_idle_outputs("rst_mid");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            chk("post_rst_done", done_m, 1'b0);
            chk("post_rst_ready", rdy_m, 1'b1);
        end
        issue_m(8'h3C);
        done_window_m("3c", 9);

        // 01, LSB first, consumer ready toggling 1,0,1,0...
        @(posedge clk); #1;
        d_l  = 8'h01;
        ld_l = 1'b1;
        r_l  = 1'b1;
        for (int i = 0; i < 8; i++) q_l.push_back(d_l[i]);
        @(posedge clk); #1;
        ld_l = 1'b0;
        for (int e = 0; e <= 16; e++) begin
            @(negedge clk);
            chk("lsb_done", done_l, e == 15);
            @(posedge clk); #1;
            r_l = (e % 2 == 1);
        end
        r_l = 1'b1;

        // WIDTH=1, ld held high: three words at a 2-cycle period
        @(posedge clk); #1;
        d_1  = 1'b1;
        ld_1 = 1'b1;
        for (int i = 0; i < 3; i++) q_1.push_back(1'b1);
        @(posedge clk); #1;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            chk("w1_valid", sv_1, (e % 2 == 0) && (e <= 4));
            chk("w1_done", done_1, (e % 2 == 1) && (e <= 5));
            chk("w1_ready", rdy_1, !((e % 2 == 0) && (e <= 4)));
            @(posedge clk); #1;
            if (e == 3) ld_1 = 1'b0;
        end

        repeat (3) @(negedge clk);
        n_vec++;
        if (q_m.size() != 0 || q_l.size() != 0 || q_1.size() != 0) begin
            n_err++;
            $display("FAIL leftover_bits: m=%0d l=%0d w1=%0d expected 0 0 0",
                     q_m.size(), q_l.size(), q_1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
